uart_frame_packer: RTL and testbench

Parametrised serializer for the board-to-board game-state link. On each frame request it snapshots N_CH payload channels and tags each one. It then emits a framed byte stream (sync byte, tagged words MSB-first, additive checksum) to the UART transmitter over a valid/ready byte handshake. It sits between the game-logic registers (player/ball positions, score/control word) and uart_tx on the master board.

---
 rtl/uart_link_pkg.sv | 30 +++
 rtl/frame_checksum.sv | 19 +
 rtl/uart_frame_packer.sv | 130 +++++++++++++
 tb/tb_uart_frame_packer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// Shared definitions for the board-to-board game-state link.
// Imported by both the master-side packer and the slave-side unpacker.
package uart_link_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    CSUM
  } link_state_e;

  // Tag 0 is reserved so the receiver can reject an all-zero word.
  function automatic int unsigned tag_of(input int unsigned ch);
    return ch + 1;
  endfunction

  function automatic int unsigned word_bytes(input int unsigned tag_w,
                                             input int unsigned payload_w);
    return (tag_w + payload_w + 7) / 8;
  endfunction

  // Sync byte + tagged words + checksum byte.
  function automatic int unsigned frame_len(input int unsigned n_ch,
                                            input int unsigned wbytes);
    return 2 + n_ch * wbytes;
  endfunction

endpackage

// File: rtl/frame_checksum.sv
// 8-bit additive checksum accumulator with synchronous clear and add-enable.
module frame_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] add_data,
  output logic [7:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_data;
    end
  end

endmodule

// File: rtl/uart_frame_packer.sv
// Snapshots N_CH payload channels on start and streams a framed byte sequence
// (sync, tagged words MSB-first, checksum) over a valid/ready byte handshake.
module uart_frame_packer
  import uart_link_pkg::*;
#(
  parameter int unsigned N_CH      = 7,
  parameter int unsigned PAYLOAD_W = 12,
  parameter int unsigned TAG_W     = 4,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_CH*PAYLOAD_W-1:0] ch_data,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun
);

  localparam int unsigned WORD_BYTES = word_bytes(TAG_W, PAYLOAD_W);
  localparam int unsigned WORD_W     = WORD_BYTES * 8;
  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned BY_W       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
  localparam logic [BY_W-1:0] BY_LAST = BY_W'(WORD_BYTES - 1);

  link_state_e state, state_next;

  logic [PAYLOAD_W-1:0] snap [N_CH];
  logic [CH_W-1:0]      ch;
  logic [BY_W-1:0]      byte_idx;
  logic [WORD_W-1:0]    word;
  logic [7:0]           cur_byte;
  logic [7:0]           csum;
  logic                 xfer;
  logic                 accept;

  assign xfer   = tx_valid && tx_ready;
  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = SYNC;
      SYNC: if (xfer)  state_next = DATA;
      DATA: if (xfer && byte_idx == '0 && ch == CH_LAST) state_next = CSUM;
      CSUM: if (xfer)  state_next = IDLE;
      default:         state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE: ;
      SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = cur_byte;
      end
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
      end
      default: ;
    endcase
  end

  // Word = {tag, payload}, zero-extended on the left to a whole number of bytes.
  always_comb begin
    word                     = '0;
    word[PAYLOAD_W-1:0]      = snap[ch];
    word[PAYLOAD_W +: TAG_W] = TAG_W'(tag_of(32'(ch)));
    cur_byte                 = word[byte_idx*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch         <= '0;
      byte_idx   <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) snap[i] <= '0;
    end else begin
      frame_done <= (state == CSUM) && xfer;
      overrun    <= start && (state != IDLE);
      if (accept) begin
        for (int unsigned i = 0; i < N_CH; i++)
          snap[i] <= ch_data[i*PAYLOAD_W +: PAYLOAD_W];
      end
      if (state == SYNC && xfer) begin
        ch       <= '0;
        byte_idx <= BY_LAST;
      end else if (state == DATA && xfer) begin
        if (byte_idx != '0) begin
          byte_idx <= byte_idx - 1'b1;
        end else if (ch != CH_LAST) begin
          ch       <= ch + 1'b1;
          byte_idx <= BY_LAST;
        end
      end
    end
  end

  frame_checksum u_csum (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .add_en   ((state == DATA) && xfer),
    .add_data (tx_data),
    .sum      (csum)
  );

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed bench for uart_frame_packer: hand-computed frames, stall, snapshot,
// overrun, mid-frame reset and back-to-back frame scenarios.
module tb_uart_frame_packer;

  localparam int N_CH      = 7;
  localparam int PAYLOAD_W = 12;
  localparam int CHW       = N_CH * PAYLOAD_W;

  typedef logic [7:0] frame_t [16];

  logic           clk;
  logic           rst;
  logic           start;
  logic [CHW-1:0] ch_data;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           busy;
  logic           frame_done;
  logic           overrun;

  uart_frame_packer #(
    .N_CH      (N_CH),
    .PAYLOAD_W (PAYLOAD_W),
    .TAG_W     (4),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ch_data    (ch_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         ov_n     = 0;
  int         busy_gaps;
  bit         scramble = 0;
  logic [7:0] rx [$];
  frame_t     exp0;
  frame_t     exp1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    else n_pass++;
  endtask

  // Captures the byte transferring at the coming edge, then samples 1ns after it.
  task automatic tick();
    if (tx_valid === 1'b1 && tx_ready === 1'b1) rx.push_back(tx_data);
    @(posedge clk);
    #1;
    cyc++;
    if (overrun === 1'b1) ov_n++;
    if (scramble) ch_data = CHW'({$urandom(), $urandom(), $urandom()});
  endtask

  task automatic collect_frame(input int budget, output int fd_at);
    fd_at     = -1;
    busy_gaps = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (frame_done === 1'b1) begin
        fd_at = cyc;
        break;
      end
      if (busy !== 1'b1) busy_gaps++;
    end
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < 40 && rx.size() < n; i++) tick();
  endtask

  task automatic check_frame(input string tag, input frame_t exp_f);
    check({tag, "_len"}, rx.size(), 16);
    for (int i = 0; i < 16 && i < rx.size(); i++)
      check($sformatf("%s_b%0d", tag, i), rx[i], exp_f[i]);
  endtask

  // Pulses start for one edge; afterwards SYNC must already be presented.
  task automatic kick(input string tag);
    rx.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_sync_valid"}, tx_valid, 1'b1);
    check({tag, "_sync_data"}, tx_data, 8'hA5);
  endtask

  int fd;
  int s;

  initial begin
    exp0 = '{8'hA5, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h40,
             8'h00, 8'h50, 8'h00, 8'h60, 8'h00, 8'h70, 8'h00, 8'hC0};
    exp1 = '{8'hA5, 8'h11, 8'h23, 8'h20, 8'h00, 8'h30, 8'h00, 8'h40,
             8'h00, 8'h50, 8'h00, 8'h60, 8'h00, 8'h70, 8'h00, 8'hE4};

    rst = 1'b1; start = 1'b0; tx_ready = 1'b1; ch_data = '0;
    repeat (3) tick();
    check("rst_valid", tx_valid, 1'b0);
    check("rst_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    rst = 1'b0;
    tick();

    // All-zero payloads, ready always high
    kick("t1");
    s = cyc;
    collect_frame(40, fd);
    check_frame("t1", exp0);
    check("t1_done_at", fd - s, 16);
    check("t1_busy_gaps", busy_gaps, 0);
    tick();
    check("t1_done_pulse", frame_done, 1'b0);
    check("t1_idle_busy", busy, 1'b0);

    // Channel 0 = 0x123
    ch_data = CHW'(12'h123);
    kick("t2");
    collect_frame(40, fd);
    check_frame("t2", exp1);
    tick();

    // Snapshot isolation: inputs scrambled every cycle after acceptance
    ch_data = CHW'(12'h123);
    kick("t3");
    scramble = 1;
    ch_data  = '1;
    collect_frame(40, fd);
    scramble = 0;
    check_frame("t3", exp1);
    check("t3_done_seen", fd > 0, 1'b1);
    tick();

    // Back-pressure: ready low for 5 cycles while byte index 3 is presented
    ch_data = '0;
    kick("t4");
    wait_bytes(3);
    tx_ready = 1'b0;
    check("t4_stall_data", tx_data, 8'h20);
    begin
      int unstable = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (tx_data !== 8'h20 || tx_valid !== 1'b1) unstable++;
      end
      check("t4_stable", unstable, 0);
    end
    tx_ready = 1'b1;
    collect_frame(40, fd);
    check_frame("t4", exp0);
    tick();

    // Start while busy: overrun pulse, frame unaffected, no queued frame
    ov_n = 0;
    kick("t5");
    wait_bytes(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_ovr_pulse", overrun, 1'b1);
    tick();
    check("t5_ovr_clear", overrun, 1'b0);
    collect_frame(40, fd);
    check_frame("t5", exp0);
    check("t5_ovr_count", ov_n, 1);
    repeat (3) tick();
    check("t5_no_queue_busy", busy, 1'b0);
    check("t5_no_queue_valid", tx_valid, 1'b0);
    check("t5_no_queue_len", rx.size(), 16);

    // Reset mid-frame aborts, next frame is clean
    kick("t6");
    wait_bytes(6);
    check("t6_reach", rx.size(), 6);
    rst = 1'b1;
    tick();
    check("t6_rst_valid", tx_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_data", tx_data, 8'h00);
    rst = 1'b0;
    tick();
    kick("t6b");
    collect_frame(40, fd);
    check_frame("t6b", exp0);

    // Start during frame_done cycle is accepted immediately
    ch_data = CHW'(12'h123);
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("t7_b2b_valid", tx_valid, 1'b1);
    check("t7_b2b_data", tx_data, 8'hA5);
    check("t7_b2b_ovr", overrun, 1'b0);
    rx.delete();
    collect_frame(40, fd);
    check_frame("t7", exp1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
